// File: rtl/audio_step_sequencer.sv
// audio_step_sequencer: turns direction+count tracking commands into timed step/dir pulses
// with soft position limits and a post-move settle hold-off.
module audio_step_sequencer #(
    parameter int unsigned STEP_PERIOD   = 50000,
    parameter int unsigned PULSE_WIDTH   = 100,
    parameter int unsigned DIR_SETUP     = 50,
    parameter int unsigned SETTLE_CYCLES = 250000,
    parameter logic [7:0]  MAX_STEPS     = 8'd64,
    parameter logic [15:0] POS_LIMIT     = 16'd2000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        enable_i,
    input  logic        cmd_valid_i,
    input  logic        cmd_dir_i,
    input  logic [7:0]  cmd_val_i,
    output logic        cmd_ack_o,
    output logic        busy_o,
    output logic        dir_out_o,
    output logic        step_out_o,
    output logic [15:0] position_o,
    output logic        limit_hit_o
);
    localparam logic [2:0] S_IDLE = 3'd0, S_SETUP = 3'd1, S_PULSE = 3'd2, S_GAP = 3'd3, S_SETTLE = 3'd4;
    localparam logic signed [15:0] LIM = POS_LIMIT;
    logic              en_q, vld_q, cdir_q;
    logic [7:0]        cval_q;
    logic [2:0]        state_q, state_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [7:0]        rem_q, rem_d, clamp;
    logic signed [15:0] pos_q, pos_d;
    logic              dir_q, dir_d, step_q, step_d, ack_q, ack_d, busy_q, busy_d, lim_q, lim_d;
    logic              chk, settle, at_lim;
    // Commands are registered first, so acceptance lands one edge after sampling.
    assign clamp  = (cval_q > MAX_STEPS) ? MAX_STEPS : cval_q;
    assign at_lim = dir_q ? (pos_q == -LIM) : (pos_q == LIM);
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        pos_d   = pos_q;
        dir_d   = dir_q;
        step_d  = step_q;
        ack_d   = 1'b0;
        busy_d  = busy_q;
        lim_d   = 1'b0;
        chk     = 1'b0;
        settle  = 1'b0;
        case (state_q)
            S_IDLE: if (en_q && vld_q) begin
                ack_d = 1'b1;
                dir_d = cdir_q;
                rem_d = clamp;
                if (clamp != '0) begin
                    state_d = S_SETUP;
                    busy_d  = 1'b1;
                    cnt_d   = DIR_SETUP - 1;
                end
            end
            S_SETUP: if (!en_q) settle = 1'b1;
                     else if (cnt_q == '0) chk = 1'b1;
                     else cnt_d = cnt_q - 1;
            S_PULSE: begin
                cnt_d = cnt_q - 1;
                if (cnt_q == STEP_PERIOD - PULSE_WIDTH) begin
                    step_d  = 1'b0;
                    state_d = S_GAP;
                end
            end
            S_GAP: if (cnt_q != '0) cnt_d = cnt_q - 1;
                   else if (rem_q != '0 && en_q) chk = 1'b1;
                   else settle = 1'b1;
            S_SETTLE: if (cnt_q == '0) begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end else cnt_d = cnt_q - 1;
            default: state_d = S_IDLE;
        endcase
        if (chk && at_lim) begin
            lim_d  = 1'b1;
            rem_d  = '0;
            settle = 1'b1;
        end else if (chk) begin
            state_d = S_PULSE;
            step_d  = 1'b1;
            pos_d   = dir_q ? pos_q - 16'sd1 : pos_q + 16'sd1;
            rem_d   = rem_q - 8'd1;
            cnt_d   = STEP_PERIOD - 1;
        end
        if (settle) begin
            state_d = S_SETTLE;
            cnt_d   = SETTLE_CYCLES - 1;
        end
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            {en_q, vld_q, cdir_q, cval_q} <= '0;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            pos_q   <= '0;
            {dir_q, step_q, ack_q, busy_q, lim_q} <= '0;
        end else begin
            {en_q, vld_q, cdir_q, cval_q} <= {enable_i, cmd_valid_i, cmd_dir_i, cmd_val_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            pos_q   <= pos_d;
            {dir_q, step_q, ack_q, busy_q, lim_q} <= {dir_d, step_d, ack_d, busy_d, lim_d};
        end
    end
    assign cmd_ack_o   = ack_q;
    assign busy_o      = busy_q;
    assign dir_out_o   = dir_q;
    assign step_out_o  = step_q;
    assign position_o  = pos_q;
    assign limit_hit_o = lim_q;
endmodule
